i2c_cmd_sequencer: RTL

Command front-end that sits directly upstream of the I2C master driver. It buffers host transactions (RW, 10-bit address, data byte) in a command FIFO and issues them one at a time over the driver's start/busy interface. Each transaction runs to completion, with timeouts, and returns an in-order response (read data or error) through a response FIFO. The host therefore never handles the driver's slow SCL-domain handshake directly.

---
 rtl/i2c_seq_pkg.sv | 28 ++
 rtl/i2c_cmd_sequencer_if.sv | 40 ++++
 rtl/i2c_seq_fifo.sv | 56 +++++
 rtl/i2c_cmd_sequencer.sv | 137 +++++++++++++
 4 files changed

// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C command sequencer.
//   seq_state_e : sequencer FSM states
//   cmd_t       : queued host command {rw, addr, data}
//   rsp_t       : queued response {err, data}
package i2c_seq_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StIssue    = 2'd1,
        StWaitDone = 2'd2,
        StRespond  = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic       rw;
        logic [9:0] addr;
        logic [7:0] data;
    } cmd_t;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } rsp_t;

    localparam int unsigned CmdW = $bits(cmd_t);
    localparam int unsigned RspW = $bits(rsp_t);

endpackage

// File: rtl/i2c_cmd_sequencer_if.sv
// Bus bundle of the I2C command sequencer: host command/response side plus the
// start/busy handshake towards the I2C master driver.
//   master : host and driver side (drives commands, rsp_ready, drv_busy/rdata)
//   slave  : sequencer side
interface i2c_cmd_sequencer_if #(
    parameter int unsigned CMD_DEPTH = 4
);
    localparam int unsigned CntW = $clog2(CMD_DEPTH + 1);

    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_rw;
    logic [9:0]      cmd_addr;
    logic [7:0]      cmd_data;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [7:0]      rsp_data;
    logic            rsp_err;
    logic            drv_start;
    logic            drv_rw;
    logic [9:0]      drv_addr;
    logic [7:0]      drv_data;
    logic            drv_busy;
    logic [7:0]      drv_rdata;
    logic            seq_idle;
    logic [CntW-1:0] cmd_count;

    modport master (
        output cmd_valid, cmd_rw, cmd_addr, cmd_data, rsp_ready, drv_busy, drv_rdata,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, drv_start, drv_rw, drv_addr, drv_data,
        input  seq_idle, cmd_count
    );

    modport slave (
        input  cmd_valid, cmd_rw, cmd_addr, cmd_data, rsp_ready, drv_busy, drv_rdata,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, drv_start, drv_rw, drv_addr, drv_data,
        output seq_idle, cmd_count
    );

endinterface

// File: rtl/i2c_seq_fifo.sv
// Synchronous show-ahead FIFO with occupancy count.
//   push/wdata : write, ignored when full (no pop bypass)
//   pop        : read, ignored when empty
//   rdata      : head entry, forced to zero while empty
//   empty/count: occupancy
module i2c_seq_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        do_push = push && (count_q != CntW'(DEPTH));
        do_pop  = pop && (count_q != '0);
        wptr_d  = do_push ? wptr_q + PtrW'(1) : wptr_q;
        rptr_d  = do_pop ? rptr_q + PtrW'(1) : rptr_q;
        count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = empty ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Buffers host I2C transactions and runs them one at a time against the master
// driver's level start / busy handshake, returning one in-order response each.
//   clk, rst : clock, synchronous active-high reset
//   bus      : host command/response and driver handshake (slave modport)
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int unsigned CMD_DEPTH     = 4,
    parameter int unsigned RSP_DEPTH     = 4,
    parameter int unsigned START_TIMEOUT = 1023,
    parameter int unsigned XFER_TIMEOUT  = 65535
) (
    input logic                clk,
    input logic                rst,
    i2c_cmd_sequencer_if.slave bus
);
    localparam int unsigned CntW    = $clog2(CMD_DEPTH + 1);
    localparam int unsigned RspCntW = $clog2(RSP_DEPTH + 1);
    localparam int unsigned MaxTo   = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT
                                                                     : XFER_TIMEOUT;
    localparam int unsigned TmrW    = $clog2(MaxTo + 1);

    seq_state_e        state_q, state_d;
    logic [TmrW-1:0]   tmr_q, tmr_d;
    cmd_t              drv_q, drv_d;
    logic              drv_start_q, drv_start_d;
    rsp_t              rsp_q, rsp_d;

    cmd_t              cmd_in, cmd_head;
    logic              cmd_push, cmd_pop, cmd_empty;
    logic [CntW-1:0]   cmd_cnt;
    rsp_t              rsp_head;
    logic              rsp_push, rsp_pop, rsp_empty, rsp_full;
    logic [RspCntW-1:0] rsp_cnt;

    assign cmd_in   = '{rw: bus.cmd_rw, addr: bus.cmd_addr, data: bus.cmd_data};
    assign cmd_push = bus.cmd_valid && bus.cmd_ready;
    assign rsp_pop  = bus.rsp_ready && !rsp_empty;
    assign rsp_full = (rsp_cnt == RspCntW'(RSP_DEPTH));

    i2c_seq_fifo #(.WIDTH(CmdW), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_push),
        .wdata (cmd_in),
        .pop   (cmd_pop),
        .rdata (cmd_head),
        .empty (cmd_empty),
        .count (cmd_cnt)
    );

    i2c_seq_fifo #(.WIDTH(RspW), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_push),
        .wdata (rsp_q),
        .pop   (rsp_pop),
        .rdata (rsp_head),
        .empty (rsp_empty),
        .count (rsp_cnt)
    );

    always_comb begin
        state_d     = state_q;
        drv_d       = drv_q;
        rsp_d       = rsp_q;
        drv_start_d = 1'b0;
        cmd_pop     = 1'b0;
        rsp_push    = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Requiring a free response slot here guarantees RESPOND never stalls.
                // Requiring !drv_busy also holds off after a stuck-busy timeout.
                if (!cmd_empty && !rsp_full && !bus.drv_busy) begin
                    state_d = StIssue;
                    cmd_pop = 1'b1;
                    drv_d   = cmd_head;
                end
            end
            StIssue: begin
                if (bus.drv_busy) begin
                    state_d = StWaitDone;
                end else if (tmr_q == TmrW'(START_TIMEOUT)) begin
                    state_d = StRespond;
                    rsp_d   = '{err: 1'b1, data: 8'h00};
                end else begin
                    drv_start_d = 1'b1;
                end
            end
            StWaitDone: begin
                // Completion is tested first so it wins over a coincident timeout.
                if (!bus.drv_busy) begin
                    state_d = StRespond;
                    rsp_d   = '{err: 1'b0, data: drv_q.rw ? bus.drv_rdata : 8'h00};
                end else if (tmr_q == TmrW'(XFER_TIMEOUT)) begin
                    state_d = StRespond;
                    rsp_d   = '{err: 1'b1, data: 8'h00};
                end
            end
            StRespond: begin
                rsp_push = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Restart the timeout on every state change, i.e. on ISSUE/WAIT_DONE entry.
        tmr_d = (state_d != state_q) ? '0 : tmr_q + TmrW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            tmr_q       <= '0;
            drv_q       <= '0;
            drv_start_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            drv_q       <= drv_d;
            drv_start_q <= drv_start_d;
            rsp_q       <= rsp_d;
        end
    end

    assign bus.cmd_ready = (cmd_cnt != CntW'(CMD_DEPTH));
    assign bus.cmd_count = cmd_cnt;
    assign bus.rsp_valid = !rsp_empty;
    assign bus.rsp_data  = rsp_head.data;
    assign bus.rsp_err   = rsp_head.err;
    assign bus.drv_start = drv_start_q;
    assign bus.drv_rw    = drv_q.rw;
    assign bus.drv_addr  = drv_q.addr;
    assign bus.drv_data  = drv_q.data;
    assign bus.seq_idle  = (state_q == StIdle) && cmd_empty;

endmodule
